wait_sequencer: RTL
===================

# wait_sequencer

Parametrised successor to the team's fixed three-cycle wait FSM. It counts a programmable delay, asserts `out` and holds it until `ack` arrives, then either re-arms automatically or returns to idle, depending on mode. It adds a programmable delay width and value, start/abort control, a one-shot/auto-repeat mode, and status outputs. It sits between a control register block and any datapath stage that must wait a fixed interval and then request acknowledgement.

## Interface
Parameters:
- `CNT_W`, default 8: width of the delay counter and `cfg_delay`.
- `DEF_DELAY`, default 3: delay loaded at reset; must fit in `CNT_W` bits.
- `AUTO_START`, default 1: 1 means reset enters COUNT; 0 means reset enters IDLE.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_load`  in  1  loads `cfg_delay` into the delay register; honoured only in IDLE.
- `cfg_delay`  in  CNT_W  delay value in cycles; 0 is treated as 1.
- `cfg_auto`  in  1  sampled when leaving HOLD. 1 means re-arm; 0 means go to IDLE.
- `start`  in  1  leaves IDLE for COUNT; ignored in any other state.
- `ack`  in  1  acknowledges `out`; acts only in HOLD.
- `abort`  in  1  forces IDLE from any state; highest priority after `rst`.
- `out`  out  1  high exactly while in HOLD.
- `busy`  out  1  high while in COUNT.
- `done_pulse`  out  1  one-cycle pulse on the first cycle of HOLD.
- `remaining`  out  CNT_W  current counter value in COUNT; 0 in other states.
- `err`  out  1  sticky flag. Set by `ack` outside HOLD, or by `cfg_load`/`start` outside IDLE. Cleared by `rst` or by an honoured `cfg_load`.

## Operation
- States: IDLE, COUNT, HOLD. `out` and `busy` are decoded from the state register (Moore).
- On reset:
  - The delay register takes `max(DEF_DELAY,1)`.
  - State goes to COUNT (AUTO_START=1), with the counter loaded from the delay register, or to IDLE (AUTO_START=0).
  - `err` = 0.
  - Outputs during reset reflect the reset state: `out`=0, `done_pulse`=0, `busy`=AUTO_START.
- IDLE:
  - `cfg_load` writes the delay register.
  - `start` moves to COUNT and loads the counter. If `cfg_load` and `start` occur in the same cycle, the counter takes the new value, not the old register.
- COUNT:
  - The counter decrements every cycle.
  - When the counter is 1, the next state is HOLD.
- HOLD:
  - `out` = 1 until `ack`.
  - On `ack` with `cfg_auto`=1: go to COUNT and reload the counter from the delay register.
  - On `ack` with `cfg_auto`=0: go to IDLE.
- Priority each cycle: `rst` > `abort` > state-specific inputs.
  - `abort` together with `ack` goes to IDLE with no re-arm.
  - `abort` in IDLE has no effect.
- Counter width rule:
  - The delay register holds the value clamped to ≥1, so no underflow or wrap is possible.
  - `cfg_delay` of all ones gives the maximum delay of 2^CNT_W−1 cycles.

## Timing
- Latency from `start` to `out`: `start` sampled at edge t gives COUNT from t+1 and HOLD from t+1+D. `out` and `done_pulse` go high in cycle t+1+D.
- Reset with AUTO_START=1: `out` rises after exactly D rising edges with `rst` low. With D=3 this matches the previous fixed FSM.
- `ack` in HOLD at edge h: `out` is low in cycle h+1. With auto mode, `out` returns in cycle h+1+D.
- Minimum HOLD length is 1 cycle, when `ack` is already high on entry.
- `abort` at edge a: `out`, `busy` and `remaining` are 0 from cycle a+1.
- `rst` mid-COUNT or mid-HOLD: the reset state is entered on that edge and the delay register returns to DEF_DELAY.
- Loads into the delay register do not affect a count already in progress.

## Structure
- Shared package `wait_seq_pkg` holds the state encoding localparams (IDLE=2'b00, COUNT=2'b01, HOLD=2'b10) and the clamp-to-one helper function.
- One sub-module, `delay_counter`: a CNT_W down-counter with `load`, `load_val`, `en`, `value`, and `is_one` outputs. The FSM, delay register, and `err` logic live in `wait_sequencer`.

## Test plan
- Reset with AUTO_START=1, DEF_DELAY=3, `ack`=0 → `out`=0 for 3 cycles after `rst` falls, then `out`=1 and `done_pulse`=1 for one cycle; `out` stays 1 for 20 cycles.
- AUTO_START=0: `cfg_load` with `cfg_delay`=5 and `start` in the same cycle → `remaining` reads 5,4,3,2,1; `out` rises 6 cycles after the `start` edge.
- HOLD with `ack`=1 and `cfg_auto`=1, D=2 → `out` pattern 1,0,0,1. With `cfg_auto`=0 → `out` 1 then IDLE, `busy`=0.
- `cfg_delay`=0 → behaves as 1: `out` high 2 cycles after `start`. `cfg_delay`=255 with CNT_W=8 → HOLD after 256 cycles.
- `abort` asserted with `ack` in HOLD → IDLE next cycle and no re-arm. `abort` mid-COUNT at `remaining`=4 → `remaining`=0, `busy`=0 next cycle.
- `ack` in COUNT → `err`=1 and the count is unaffected. A later `cfg_load` in IDLE → `err`=0.

Source files
------------

// File: rtl/wait_seq_pkg.sv
// wait_seq_pkg
//   Shared definitions for the wait sequencer:
//   - State encoding (IDLE=00, COUNT=01, HOLD=10) as localparams, plus an
//     enum built on them.
//   - clamp1(): maps a zero delay to one, so the down-counter can never
//     underflow.
package wait_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COUNT = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    HOLD  = ST_HOLD
  } state_t;

  // Width used by the helper; callers cast to and from their own CNT_W.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] clamp1(input logic [MAX_W-1:0] v);
    return (v == '0) ? MAX_W'(1) : v;
  endfunction

endpackage

// File: rtl/wait_sequencer_delay_counter.sv
// delay_counter
//   CNT_W-bit down-counter. It has no reset of its own: the parent drives
//   `load` during reset, so the counter always starts from a defined value.
//   Ports:
//     clk      in   clock
//     load     in   load load_val (has priority over en)
//     load_val in   value to load
//     en       in   decrement by one
//     value    out  current count
//     is_one   out  value == 1 (final cycle of the count)
module delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (load)
      value <= load_val;
    else if (en)
      value <= value - CNT_W'(1);
  end

  assign is_one = (value == CNT_W'(1));

endmodule

// File: rtl/wait_sequencer.sv
// wait_sequencer
//   Counts a programmable delay, then raises `out` and holds it until `ack`.
//   After `ack` it either re-arms (cfg_auto=1) or returns to idle.
//   Ports:
//     clk, rst    clock and synchronous active-high reset
//     cfg_load    write cfg_delay into the delay register (IDLE only)
//     cfg_delay   delay in cycles (0 behaves as 1)
//     cfg_auto    re-arm select, sampled when leaving HOLD
//     start       IDLE -> COUNT
//     ack         acknowledges out (HOLD only)
//     abort       forces IDLE from COUNT/HOLD
//     out         high while in HOLD
//     busy        high while in COUNT
//     done_pulse  one-cycle pulse on the first cycle of HOLD
//     remaining   counter value in COUNT, else 0
//     err         sticky misuse flag; cleared by rst or an honoured cfg_load
module wait_sequencer
  import wait_seq_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int DEF_DELAY  = 3,
  parameter int AUTO_START = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic             cfg_auto,
  input  logic             start,
  input  logic             ack,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] remaining,
  output logic             err
);

  localparam logic [CNT_W-1:0] DEF_CLAMP = CNT_W'(clamp1(MAX_W'(DEF_DELAY)));

  state_t           state;
  logic [CNT_W-1:0] delay_reg;
  logic [CNT_W-1:0] new_delay;
  logic             in_idle, in_count, in_hold;
  logic             ld_ok, go_start, rearm, err_set;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_is_one;

  assign in_idle  = (state == IDLE);
  assign in_count = (state == COUNT);
  assign in_hold  = (state == HOLD);

  assign new_delay = CNT_W'(clamp1(MAX_W'(cfg_delay)));
  assign ld_ok     = in_idle & cfg_load;
  assign go_start  = in_idle & start;
  assign rearm     = in_hold & ack & cfg_auto & ~abort;
  assign err_set   = (ack & ~in_hold) | ((cfg_load | start) & ~in_idle);

  // The counter is also loaded during reset so that AUTO_START begins a
  // full count. A same-cycle load+start takes the new value directly,
  // bypassing the delay register, which only updates on the next edge.
  assign cnt_load = rst | go_start | rearm;
  always_comb begin
    cnt_val = delay_reg;
    if (rst)
      cnt_val = DEF_CLAMP;
    else if (go_start && cfg_load)
      cnt_val = new_delay;
  end

  delay_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (in_count),
    .value    (cnt_value),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= (AUTO_START != 0) ? COUNT : IDLE;
      delay_reg  <= DEF_CLAMP;
      err        <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (ld_ok)
        delay_reg <= new_delay;
      // A fresh misuse in the same cycle as a clearing load still sets err.
      if (err_set)
        err <= 1'b1;
      else if (ld_ok)
        err <= 1'b0;
      // abort only matters outside IDLE; in IDLE normal inputs still act.
      if (abort && !in_idle) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:  if (start) state <= COUNT;
          COUNT: if (cnt_is_one) begin
                   state      <= HOLD;
                   done_pulse <= 1'b1;
                 end
          HOLD:  if (ack) state <= cfg_auto ? COUNT : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign out       = in_hold;
  assign busy      = in_count;
  assign remaining = in_count ? cnt_value : '0;

endmodule
